e_mdu: RTL

//   Execute-stage multiply/divide unit. Consumes the rs/rt operand values

---
 rtl/e_mdu.sv | 132 +++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// Multiply/divide unit owning HI/LO: MULT* busy MULT_CYCLES, DIV* busy DIV_CYCLES, MTHI/MTLO immediate.
// No backpressure of its own: start while busy is dropped, the hazard unit stalls D instead.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           wr_q, wr_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic [31:0]    tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

  logic [63:0]    prod_s, prod_u;
  logic [31:0]    div_b, quot_s, rem_s, quot_u, rem_u;
  logic           div_ovf, div_zero;

  always_comb begin
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    // A zero divisor is replaced so the dividers never produce X; the result is discarded anyway.
    div_b    = div_zero ? 32'd1 : rt_val;
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    quot_s   = div_ovf ? 32'h8000_0000 : 32'($signed(rs_val) / $signed(div_b));
    rem_s    = div_ovf ? 32'd0         : 32'($signed(rs_val) % $signed(div_b));
    quot_u   = rs_val / div_b;
    rem_u    = rs_val % div_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT, OP_MULTU: begin
              {tmp_hi_d, tmp_lo_d} = (mdu_op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              wr_d    = 1'b1;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              tmp_hi_d = (mdu_op == OP_DIV) ? rem_s  : rem_u;
              tmp_lo_d = (mdu_op == OP_DIV) ? quot_s : quot_u;
              cnt_d    = CW'(DIV_CYCLES);
              busy_d   = 1'b1;
              wr_d     = !div_zero;
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (mdu_op == OP_MFHI) ? hi_q : lo_q;

endmodule
